// File: rtl/proteus_bus_arbiter.sv
// proteus_bus_arbiter
//   Shares one memory command/response port between the fetch bus (ibus) and the
//   load/store bus (dbus). Commands are arbitrated with zero-cycle latency, and a grant
//   is held until its handshake completes. The source ID of each accepted command is
//   queued in order, so that each in-order memory response is routed back to its issuer.
//
// Configuration macro:
//   PROTEUS_ARB_RR_EN  defined:   round-robin between simultaneous requesters
//                      undefined: fixed priority, dbus over ibus
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   ibus_cmd_* / ibus_rsp_*     fetch command (address only) and response (rdata)
//   dbus_cmd_* / dbus_rsp_*     data command (address/write/wdata/wmask) and response
//   mem_cmd_* / mem_rsp_*       shared memory command and in-order response port
//   outst_cnt                   number of commands accepted but not yet answered
//   err_orphan_rsp              sticky flag: a response arrived with nothing outstanding
module proteus_bus_arbiter #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           ibus_cmd_valid,
    output logic                           ibus_cmd_ready,
    input  logic [AW-1:0]                  ibus_cmd_payload_address,
    output logic                           ibus_rsp_valid,
    input  logic                           ibus_rsp_ready,
    output logic [DW-1:0]                  ibus_rsp_payload_rdata,

    input  logic                           dbus_cmd_valid,
    output logic                           dbus_cmd_ready,
    input  logic [AW-1:0]                  dbus_cmd_payload_address,
    input  logic                           dbus_cmd_payload_write,
    input  logic [DW-1:0]                  dbus_cmd_payload_wdata,
    input  logic [DW/8-1:0]                dbus_cmd_payload_wmask,
    output logic                           dbus_rsp_valid,
    input  logic                           dbus_rsp_ready,
    output logic [DW-1:0]                  dbus_rsp_payload_rdata,

    output logic                           mem_cmd_valid,
    input  logic                           mem_cmd_ready,
    output logic [AW-1:0]                  mem_cmd_address,
    output logic                           mem_cmd_write,
    output logic [DW-1:0]                  mem_cmd_wdata,
    output logic [DW/8-1:0]                mem_cmd_wmask,
    input  logic                           mem_rsp_valid,
    output logic                           mem_rsp_ready,
    input  logic [DW-1:0]                  mem_rsp_rdata,

    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           err_orphan_rsp
);

    localparam int unsigned CW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [CW-1:0] MaxCnt  = CW'(MAX_OUTST);
    localparam logic [PW-1:0] LastPtr = PW'(MAX_OUTST - 1);

    typedef enum logic [0:0] {StUnlocked, StLocked} lock_e;

    lock_e         lock_q;
    logic          locked_src_q;      // 0 = ibus, 1 = dbus
    logic          route_q [MAX_OUTST];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          err_q;
`ifdef PROTEUS_ARB_RR_EN
    logic          last_grant_q;
`endif

    logic grant_src;
    logic req_valid;
    logic can_issue;
    logic cmd_valid;
    logic cmd_fire;
    logic fifo_empty;
    logic head_src;
    logic rsp_ready;
    logic rsp_pop;
    logic orphan;

    // Grant selection; a locked grant always wins so a pending command is never preempted.
    always_comb begin
        grant_src = 1'b0;
        if (lock_q == StLocked) begin
            grant_src = locked_src_q;
        end else if (ibus_cmd_valid && dbus_cmd_valid) begin
`ifdef PROTEUS_ARB_RR_EN
            grant_src = ~last_grant_q;
`else
            grant_src = 1'b1;
`endif
        end else if (dbus_cmd_valid) begin
            grant_src = 1'b1;
        end
    end

    // Full check uses the registered count, so a same-cycle pop does not free a slot.
    assign can_issue = cnt_q < MaxCnt;
    assign req_valid = grant_src ? dbus_cmd_valid : ibus_cmd_valid;
    assign cmd_valid = ~reset & can_issue & req_valid;
    assign cmd_fire  = cmd_valid & mem_cmd_ready;

    assign mem_cmd_valid   = cmd_valid;
    assign mem_cmd_address = grant_src ? dbus_cmd_payload_address : ibus_cmd_payload_address;
    assign mem_cmd_write   = grant_src & dbus_cmd_payload_write;
    assign mem_cmd_wdata   = grant_src ? dbus_cmd_payload_wdata : '0;
    assign mem_cmd_wmask   = grant_src ? dbus_cmd_payload_wmask : '0;
    assign ibus_cmd_ready  = cmd_valid & ~grant_src & mem_cmd_ready;
    assign dbus_cmd_ready  = cmd_valid & grant_src & mem_cmd_ready;

    // Response routing by the oldest outstanding source ID.
    assign fifo_empty = (cnt_q == '0);
    assign head_src   = route_q[rd_ptr_q];
    // With nothing outstanding the response is swallowed so the memory cannot stall.
    assign rsp_ready  = fifo_empty ? 1'b1 : (head_src ? dbus_rsp_ready : ibus_rsp_ready);
    assign mem_rsp_ready = ~reset & rsp_ready;
    assign rsp_pop    = ~reset & ~fifo_empty & mem_rsp_valid & rsp_ready;
    assign orphan     = ~reset & fifo_empty & mem_rsp_valid;

    assign ibus_rsp_valid         = ~reset & ~fifo_empty & ~head_src & mem_rsp_valid;
    assign dbus_rsp_valid         = ~reset & ~fifo_empty & head_src & mem_rsp_valid;
    assign ibus_rsp_payload_rdata = mem_rsp_rdata;
    assign dbus_rsp_payload_rdata = mem_rsp_rdata;

    assign outst_cnt      = cnt_q;
    assign err_orphan_rsp = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q       <= StUnlocked;
            locked_src_q <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
`ifdef PROTEUS_ARB_RR_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            if (cmd_fire) begin
                lock_q <= StUnlocked;
            end else if (cmd_valid) begin
                lock_q       <= StLocked;
                locked_src_q <= grant_src;
            end

            if (cmd_fire) begin
                route_q[wr_ptr_q] <= grant_src;
                wr_ptr_q          <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PW'(1);
`ifdef PROTEUS_ARB_RR_EN
                last_grant_q      <= grant_src;
`endif
            end

            if (rsp_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PW'(1);
            end

            if (cmd_fire && !rsp_pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (!cmd_fire && rsp_pop) begin
                cnt_q <= cnt_q - CW'(1);
            end

            if (orphan) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_proteus_bus_arbiter.sv
module tb_proteus_bus_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          ibus_v, ibus_cr, ibus_rv, irr;
    logic [AW-1:0] ibus_addr;
    logic [DW-1:0] ibus_rdata;
    logic          dbus_v, dbus_cr, dbus_rv, drr, dbus_we;
    logic [AW-1:0] dbus_addr;
    logic [DW-1:0] dbus_wdata, dbus_rdata;
    logic [3:0]    dbus_wmask;
    logic          mcv, mcr, mwrite, mrv, mrr;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata, mrdata;
    logic [3:0]    mwmask;
    logic [1:0]    outst_cnt;
    logic          err_orphan;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: queue of outstanding source IDs plus grant-hold state.
    int q[$];
    bit locked_m;
    int lsrc_m;
    bit err_m;
    int last_m;
    bit ifire_last, dfire_last;

    always #5 clk = ~clk;

    proteus_bus_arbiter #(.AW(AW), .DW(DW), .MAX_OUTST(MAX)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .ibus_cmd_valid           (ibus_v),
        .ibus_cmd_ready           (ibus_cr),
        .ibus_cmd_payload_address (ibus_addr),
        .ibus_rsp_valid           (ibus_rv),
        .ibus_rsp_ready           (irr),
        .ibus_rsp_payload_rdata   (ibus_rdata),
        .dbus_cmd_valid           (dbus_v),
        .dbus_cmd_ready           (dbus_cr),
        .dbus_cmd_payload_address (dbus_addr),
        .dbus_cmd_payload_write   (dbus_we),
        .dbus_cmd_payload_wdata   (dbus_wdata),
        .dbus_cmd_payload_wmask   (dbus_wmask),
        .dbus_rsp_valid           (dbus_rv),
        .dbus_rsp_ready           (drr),
        .dbus_rsp_payload_rdata   (dbus_rdata),
        .mem_cmd_valid            (mcv),
        .mem_cmd_ready            (mcr),
        .mem_cmd_address          (maddr),
        .mem_cmd_write            (mwrite),
        .mem_cmd_wdata            (mwdata),
        .mem_cmd_wmask            (mwmask),
        .mem_rsp_valid            (mrv),
        .mem_rsp_ready            (mrr),
        .mem_rsp_rdata            (mrdata),
        .outst_cnt                (outst_cnt),
        .err_orphan_rsp           (err_orphan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are set before the call (on the falling edge); outputs are checked 1 time
    // unit later, then the model advances across the rising edge.
    task automatic step(input string tag);
        int  gsrc, h;
        bit  full, empty, e_mcv, e_icr, e_dcr, e_irv, e_drv, e_mrr, fire, pop;
        #1;
        empty = (q.size() == 0);
        h     = empty ? 0 : q[0];
        full  = (q.size() >= MAX);
        gsrc  = -1;
        if (!full) begin
            if (locked_m) gsrc = lsrc_m;
`ifdef PROTEUS_ARB_RR_EN
            else if (ibus_v && dbus_v) gsrc = (last_m == 0) ? 1 : 0;
`else
            else if (ibus_v && dbus_v) gsrc = 1;
`endif
            else if (dbus_v) gsrc = 1;
            else if (ibus_v) gsrc = 0;
        end
        e_mcv = !reset && gsrc >= 0 && ((gsrc == 1) ? dbus_v : ibus_v);
        e_icr = e_mcv && gsrc == 0 && mcr;
        e_dcr = e_mcv && gsrc == 1 && mcr;
        e_irv = !reset && !empty && h == 0 && mrv;
        e_drv = !reset && !empty && h == 1 && mrv;
        e_mrr = !reset && (empty || ((h == 0) ? irr : drr));

        chk({tag, "/mem_cmd_valid"}, 64'(mcv), 64'(e_mcv));
        chk({tag, "/ibus_cmd_ready"}, 64'(ibus_cr), 64'(e_icr));
        chk({tag, "/dbus_cmd_ready"}, 64'(dbus_cr), 64'(e_dcr));
        chk({tag, "/ibus_rsp_valid"}, 64'(ibus_rv), 64'(e_irv));
        chk({tag, "/dbus_rsp_valid"}, 64'(dbus_rv), 64'(e_drv));
        chk({tag, "/mem_rsp_ready"}, 64'(mrr), 64'(e_mrr));
        chk({tag, "/outst_cnt"}, 64'(outst_cnt), 64'(q.size()));
        chk({tag, "/err_orphan"}, 64'(err_orphan), 64'(err_m));
        if (e_mcv) begin
            chk({tag, "/addr"}, 64'(maddr), 64'((gsrc == 1) ? dbus_addr : ibus_addr));
            chk({tag, "/write"}, 64'(mwrite), 64'((gsrc == 1) ? dbus_we : 1'b0));
            chk({tag, "/wdata"}, 64'(mwdata), 64'((gsrc == 1) ? dbus_wdata : 32'h0));
            chk({tag, "/wmask"}, 64'(mwmask), 64'((gsrc == 1) ? dbus_wmask : 4'h0));
        end
        if (e_irv) chk({tag, "/ibus_rdata"}, 64'(ibus_rdata), 64'(mrdata));
        if (e_drv) chk({tag, "/dbus_rdata"}, 64'(dbus_rdata), 64'(mrdata));

        fire = e_mcv && mcr;
        pop  = !empty && mrv && e_mrr;
        ifire_last = fire && gsrc == 0;
        dfire_last = fire && gsrc == 1;

        @(posedge clk);
        if (reset) begin
            q.delete();
            locked_m = 0;
            err_m    = 0;
            last_m   = 0;
        end else begin
            if (empty && mrv) err_m = 1;
            if (pop) void'(q.pop_front());
            if (fire) begin
                q.push_back(gsrc);
                last_m   = gsrc;
                locked_m = 0;
            end else if (e_mcv) begin
                locked_m = 1;
                lsrc_m   = gsrc;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1; ibus_v = 0; ibus_addr = '0; irr = 1;
        dbus_v = 0; dbus_addr = '0; dbus_we = 0; dbus_wdata = '0; dbus_wmask = '0; drr = 1;
        mcr = 0; mrv = 0; mrdata = '0;
        locked_m = 0; lsrc_m = 0; err_m = 0; last_m = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step("reset");
        reset = 0;

        // 1: single fetch with next-cycle response
        ibus_v = 1; ibus_addr = 32'h100; mcr = 1; step("t1_cmd");
        ibus_v = 0; mrv = 1; mrdata = 32'hDEADBEEF; step("t1_rsp");
        mrv = 0; step("t1_idle");

        // 2: simultaneous requests
        ibus_v = 1; ibus_addr = 32'h200; dbus_v = 1; dbus_addr = 32'h300; step("t2_both");
        dbus_v = 0; step("t2_second");
        ibus_v = 0; mrv = 1; mrdata = 32'hA0A0A0A0; step("t2_rsp0");
        mrdata = 32'hB1B1B1B1; step("t2_rsp1");
        mrv = 0;

        // 3: stalled store holds its grant against a later fetch
        dbus_v = 1; dbus_we = 1; dbus_addr = 32'h2000; dbus_wdata = 32'h12345678;
        dbus_wmask = 4'b0011; mcr = 0; step("t3_hold0");
        ibus_v = 1; ibus_addr = 32'h400; step("t3_hold1");
        step("t3_hold2");
        mcr = 1; step("t3_fire");
        dbus_v = 0; dbus_we = 0; step("t3_ibus");
        ibus_v = 0; mrv = 1; mrdata = 32'h0; step("t3_rsp0");
        mrdata = 32'h55AA55AA; step("t3_rsp1");
        mrv = 0;

        // 4: full stall at MAX outstanding
        ibus_v = 1; ibus_addr = 32'h500; step("t4_a");
        ibus_v = 0; dbus_v = 1; dbus_addr = 32'h600; step("t4_b");
        dbus_v = 0; ibus_v = 1; ibus_addr = 32'h700; step("t4_full");
        mrv = 1; mrdata = 32'hAAAA0001; step("t4_rspA");
        mrdata = 32'hBBBB0002; step("t4_rspB");
        ibus_v = 0; mrdata = 32'hCCCC0003; step("t4_rspC");
        mrv = 0; step("t4_idle");

        // 5: response backpressure, then push+pop across pointer wrap
        ibus_v = 1; ibus_addr = 32'h800; step("t5_cmd");
        ibus_v = 0; mrv = 1; mrdata = 32'h11112222; irr = 0; step("t5_bp0");
        step("t5_bp1");
        irr = 1; step("t5_rsp");
        mrv = 0; ibus_v = 1; ibus_addr = 32'h900; step("t5_prime");
        mrv = 1;
        for (int i = 0; i < 4; i++) begin
            ibus_addr = 32'h904 + 32'(4 * i);
            mrdata = 32'hC0DE0000 + 32'(i);
            step("t5_pushpop");
        end
        ibus_v = 0; step("t5_drain");
        mrv = 0;

        // 6: orphan response, then reset with two outstanding
        mrv = 1; mrdata = 32'hBAD0BAD0; step("t6_orphan");
        mrv = 0; step("t6_sticky");
        ibus_v = 1; ibus_addr = 32'hA00; step("t6_i");
        ibus_v = 0; dbus_v = 1; dbus_addr = 32'hB00; step("t6_d");
        dbus_v = 0; reset = 1; step("t6_reset");
        reset = 0; mrv = 1; mrdata = 32'h0BAD0BAD; step("t6_after");
        mrv = 0; step("t6_orphan2");

        // reset again, then randomized traffic against the model
        reset = 1; step("rnd_reset");
        reset = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ibus_v && ($urandom % 3 == 0)) begin
                ibus_v = 1; ibus_addr = $urandom;
            end
            if (!dbus_v && ($urandom % 3 == 0)) begin
                dbus_v = 1; dbus_addr = $urandom; dbus_we = 1'($urandom);
                dbus_wdata = $urandom; dbus_wmask = 4'($urandom);
            end
            mcr    = ($urandom % 4) != 0;
            mrv    = (q.size() > 0) && (($urandom % 2) == 0);
            mrdata = $urandom;
            irr    = ($urandom % 4) != 0;
            drr    = ($urandom % 4) != 0;
            step("rnd");
            if (ifire_last) ibus_v = 0;
            if (dfire_last) dbus_v = 0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
